// File: rtl/mem_arbiter_rr_if.sv
// Requester and memory-side bundle for mem_arbiter_rr; slave is the arbiter's view,
// master is the view of whatever drives the requests and models the memory.
interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        wr;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        grant;
  logic [NUM_PORTS-1:0]        done;
  logic [DATA_W-1:0]           rdata;
  logic                        err;
  logic                        busy;
  logic                        mem_en;
  logic                        mem_wr;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        mem_valid;

  modport slave (
    input  req, wr, addr, wdata, mem_rdata, mem_valid,
    output grant, done, rdata, err, busy, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req, wr, addr, wdata, mem_rdata, mem_valid,
    input  grant, done, rdata, err, busy, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// NUM_PORTS-way arbiter onto one single-ported memory with a read watchdog.
// Fixed priority (port 0 first) by default; define ARB_RR_EN for round-robin.
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 15
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mem_arbiter_rr_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e               r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [NUM_PORTS-1:0] r_done;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_err;
  logic                 r_busy;
  logic                 r_mem_en;
  logic                 r_mem_wr;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [CNT_W-1:0]     r_cnt;

  logic                              w_win_vld;
  logic [IDX_W-1:0]                  w_win_idx;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]  w_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  w_wdata;

  assign w_addr  = bus.addr;
  assign w_wdata = bus.wdata;

`ifdef ARB_RR_EN
  logic [IDX_W-1:0] r_last;

  // Walk from the highest search offset down so the first hit after last wins.
  always_comb begin
    logic [IDX_W-1:0] v_p;
    v_p       = '0;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      v_p = IDX_W'((int'(r_last) + 1 + k) % NUM_PORTS);
      if (bus.req[v_p]) begin
        w_win_vld = 1'b1;
        w_win_idx = v_p;
      end
    end
  end
`else
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        w_win_vld = 1'b1;
        w_win_idx = IDX_W'(k);
      end
    end
  end
`endif

  // The mem_* registers double as the latched command for the whole transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cnt       <= '0;
`ifdef ARB_RR_EN
      r_last      <= IDX_W'(NUM_PORTS - 1);
`endif
    end else begin
      r_done   <= '0;
      r_err    <= 1'b0;
      r_mem_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_state     <= S_ISSUE;
            r_grant     <= NUM_PORTS'(1) << w_win_idx;
            r_busy      <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= bus.wr[w_win_idx];
            r_mem_addr  <= w_addr[w_win_idx];
            r_mem_wdata <= w_wdata[w_win_idx];
`ifdef ARB_RR_EN
            r_last      <= w_win_idx;
`endif
          end
        end
        S_ISSUE: begin
          if (r_mem_wr) begin
            r_state <= S_DONE;
            r_done  <= r_grant;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (bus.mem_valid) begin
            r_state <= S_DONE;
            r_rdata <= bus.mem_rdata;
            r_done  <= r_grant;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_state <= S_DONE;
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_done  <= r_grant;
          end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.rdata     = r_rdata;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule
